// File: rtl/cl_ddr_scrb_pkg.sv
// Shared types and sizing for the DDR scrubber: FSM encoding and burst geometry.
package cl_ddr_scrb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_AW     = 3'd1,
    ST_WDATA  = 3'd2,
    ST_WAIT_B = 3'd3,
    ST_DONE   = 3'd4
  } scrb_state_e;

  localparam int unsigned BEAT_BYTES               = 64;
  localparam int unsigned DEFAULT_BURST_LEN_MINUS1 = 15;

  function automatic logic [63:0] burst_bytes(input int unsigned len_minus1);
    return 64'((len_minus1 + 1) * BEAT_BYTES);
  endfunction

  localparam logic [63:0] BURST_BYTES = burst_bytes(DEFAULT_BURST_LEN_MINUS1);

endpackage

// File: rtl/cl_ddr_scrb.sv
// DDR scrubber: walks 0..SCRB_MAX_ADDR writing all-zero INCR bursts over AXI,
// keeping at most MAX_OUTSTANDING bursts awaiting a B response.
module cl_ddr_scrb
  import cl_ddr_scrb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH            = 512,
  parameter int unsigned SCRB_BURST_LEN_MINUS1 = 15,
  parameter logic [63:0] SCRB_MAX_ADDR         = 64'h3FFFFF,
  parameter int unsigned MAX_OUTSTANDING       = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    scrb_enable,
  output logic                    scrb_done,
  output logic                    scrb_err,
  output logic [2:0]              scrb_dbg_state,
  output logic [63:0]             scrb_dbg_addr,
  output logic [5:0]              awid,
  output logic [63:0]             awaddr,
  output logic [7:0]              awlen,
  output logic [10:0]             awuser,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [5:0]              wid,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wlast,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [5:0]              bid,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready
);

  localparam int unsigned     OW        = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [63:0]     BURST_B   = burst_bytes(SCRB_BURST_LEN_MINUS1);
  localparam logic [7:0]      LAST_BEAT = 8'(SCRB_BURST_LEN_MINUS1);
  localparam logic [OW-1:0]   MAX_OUT   = OW'(MAX_OUTSTANDING);

  scrb_state_e   state_q;
  logic [63:0]   addr_q, addr_d;
  logic [7:0]    beat_q;
  logic [OW-1:0] outst_q, outst_d;
  logic          awvalid_q, wvalid_q, wlast_q, done_q, err_q;
  logic          aw_hs, can_issue;
  logic          unused_ok;

  assign aw_hs     = awvalid_q & awready;
  assign addr_d    = addr_q + BURST_B;
  assign can_issue = outst_d < MAX_OUT;

  // A B response landing in the same cycle as an AW handshake cancels out.
  always_comb begin
    outst_d = outst_q;
    if (aw_hs && !bvalid)
      outst_d = outst_q + 1'b1;
    else if (!aw_hs && bvalid && outst_q != '0)
      outst_d = outst_q - 1'b1;
  end

  // NOTE: every register here uses <= so all branches see pre-edge values and
  // the later err_q set cleanly overrides the clear on IDLE->AW.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      beat_q    <= '0;
      outst_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      wlast_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      outst_q <= outst_d;
      case (state_q)
        ST_IDLE: if (scrb_enable) begin
          addr_q    <= '0;
          err_q     <= 1'b0;
          awvalid_q <= 1'b1;
          state_q   <= ST_AW;
        end
        ST_AW: if (aw_hs) begin
          awvalid_q <= 1'b0;
          wvalid_q  <= 1'b1;
          beat_q    <= '0;
          wlast_q   <= (LAST_BEAT == 8'd0);
          state_q   <= ST_WDATA;
        end
        ST_WDATA: if (wready) begin
          if (wlast_q) begin
            wvalid_q <= 1'b0;
            wlast_q  <= 1'b0;
            addr_q   <= addr_d;
            if (addr_d > SCRB_MAX_ADDR || !scrb_enable || !can_issue) begin
              state_q <= ST_WAIT_B;
            end else begin
              awvalid_q <= 1'b1;
              state_q   <= ST_AW;
            end
          end else begin
            beat_q  <= beat_q + 8'd1;
            wlast_q <= (beat_q + 8'd1 == LAST_BEAT);
          end
        end
        ST_WAIT_B: begin
          if (!scrb_enable) begin
            if (outst_d == '0) state_q <= ST_IDLE;
          end else if (addr_q > SCRB_MAX_ADDR) begin
            if (outst_d == '0) begin
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end
          end else if (can_issue) begin
            awvalid_q <= 1'b1;
            state_q   <= ST_AW;
          end
        end
        ST_DONE: if (!scrb_enable) begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
      if (bvalid && bresp != 2'b00) err_q <= 1'b1;
    end
  end

  assign scrb_done      = done_q;
  assign scrb_err       = err_q;
  assign scrb_dbg_state = state_q;
  assign scrb_dbg_addr  = addr_q;
  assign awid           = '0;
  assign awaddr         = addr_q;
  assign awlen          = LAST_BEAT;
  assign awuser         = '0;
  assign awvalid        = awvalid_q;
  assign wid            = '0;
  assign wdata          = '0;
  assign wstrb          = '1;
  assign wlast          = wlast_q;
  assign wvalid         = wvalid_q;
  assign bready         = 1'b1;
  assign unused_ok      = ^bid;

endmodule
